// File: rtl/wb_m68k_master_if.sv
// Wishbone classic bus bundle between the 68k access initiator and the shared bus.
// Member names follow the initiator's view of the bus.
interface wb_m68k_master_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic [3:0]  SEL_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;
  logic        ERR_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O,
    input  DAT_I, ACK_I, ERR_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O,
    output DAT_I, ACK_I, ERR_I
  );
endinterface

// File: rtl/wb_m68k_master.sv
// Converts one CPU byte/word/long request into one or two big-endian Wishbone
// classic cycles, with odd-address faults, responder ERR and a per-phase timeout.
module wb_m68k_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  wb_m68k_master_if.master wb
);

  typedef enum logic [1:0] {StIdle, StBus1, StBus2, StResp} state_e;

  localparam logic [16:0] TmoLimit = 17'(TIMEOUT);

  state_e      state_q;
  logic [15:0] tmo_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        split_q;
  logic [31:0] dat2_q;
  logic [15:0] rhi_q;

  logic        req_fault;
  logic        req_split;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic [31:0] rd_shift;
  logic [31:0] rd_data;
  logic        tmo_hit;

  assign req_ready = (state_q == StIdle);
  assign tmo_hit   = ({1'b0, tmo_q} + 17'd1) >= TmoLimit;

  // Lane decode of the incoming request; offset 0 is the most significant lane.
  always_comb begin
    req_fault = (req_size == 2'd0) || ((req_size != 2'd1) && req_addr[0]);
    req_split = (req_size == 2'd3) && req_addr[1];
    req_sel   = 4'b0000;
    req_dat   = 32'h0;
    case (req_size)
      2'd1: begin
        req_sel = 4'b1000 >> req_addr[1:0];
        req_dat = {24'h0, req_wdata[7:0]} << {~req_addr[1:0], 3'b000};
      end
      2'd2: begin
        req_sel = req_addr[1] ? 4'b0011 : 4'b1100;
        req_dat = req_addr[1] ? {16'h0, req_wdata[15:0]} : {req_wdata[15:0], 16'h0};
      end
      2'd3: begin
        req_sel = req_addr[1] ? 4'b0011 : 4'b1111;
        req_dat = req_addr[1] ? {16'h0, req_wdata[31:16]} : req_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift = wb.DAT_I >> {~off_q, 3'b000};
    case (size_q)
      2'd1:    rd_data = {24'h0, rd_shift[7:0]};
      2'd2:    rd_data = off_q[1] ? {16'h0, wb.DAT_I[15:0]} : {16'h0, wb.DAT_I[31:16]};
      default: rd_data = wb.DAT_I;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q    <= StIdle;
      tmo_q      <= '0;
      size_q     <= '0;
      off_q      <= '0;
      split_q    <= 1'b0;
      dat2_q     <= '0;
      rhi_q      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      wb.ADR_O   <= '0;
      wb.DAT_O   <= '0;
      wb.SEL_O   <= '0;
      wb.CYC_O   <= 1'b0;
      wb.STB_O   <= 1'b0;
      wb.WE_O    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_fault) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q  <= StBus1;
              tmo_q    <= '0;
              size_q   <= req_size;
              off_q    <= req_addr[1:0];
              split_q  <= req_split;
              dat2_q   <= {req_wdata[15:0], 16'h0};
              wb.ADR_O <= {req_addr[31:2], 2'b00};
              wb.SEL_O <= req_sel;
              wb.DAT_O <= req_dat;
              wb.WE_O  <= req_we;
              wb.CYC_O <= 1'b1;
              wb.STB_O <= 1'b1;
            end
          end
        end
        StBus1, StBus2: begin
          if (wb.ERR_I || (!wb.ACK_I && tmo_hit)) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            wb.CYC_O   <= 1'b0;
            wb.STB_O   <= 1'b0;
          end else if (wb.ACK_I) begin
            if ((state_q == StBus1) && split_q) begin
              // Second half of a straddling long; CYC/STB stay asserted.
              state_q  <= StBus2;
              tmo_q    <= '0;
              rhi_q    <= wb.DAT_I[15:0];
              wb.ADR_O <= wb.ADR_O + 32'd4;
              wb.SEL_O <= 4'b1100;
              wb.DAT_O <= dat2_q;
            end else begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              if (wb.WE_O) begin
                resp_rdata <= '0;
              end else if (state_q == StBus2) begin
                resp_rdata <= {rhi_q, wb.DAT_I[31:16]};
              end else begin
                resp_rdata <= rd_data;
              end
              wb.CYC_O <= 1'b0;
              wb.STB_O <= 1'b0;
            end
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_m68k_master.sv
// Directed scoreboard bench for wb_m68k_master against a small Wishbone memory
// responder with configurable wait states, ERR injection and silence.
module tb_wb_m68k_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  wb_m68k_master_if bus ();

  wb_m68k_master #(.TIMEOUT(4)) dut (
    .CLK_I      (clk),
    .RST_I      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .wb         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        we;
  } bus_t;

  resp_t       exp_q[$];
  bus_t        bus_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mem [0:63];
  int          waits = 0;
  bit          silent = 1'b0;
  bit          err_inject = 1'b0;
  int          wcnt = 0;
  bus_t        cur_b;
  resp_t       cur_r;
  logic [5:0]  idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responder: terminates each phase after `waits` cycles and checks it against bus_q.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.ACK_I = 1'b0;
      bus.ERR_I = 1'b0;
      bus.DAT_I = 32'h0;
      wcnt = 0;
    end else begin
      if (bus.ACK_I || bus.ERR_I) begin
        bus.ACK_I = 1'b0;
        bus.ERR_I = 1'b0;
        wcnt = 0;
      end
      if (bus.CYC_O && bus.STB_O && !silent) begin
        if (wcnt >= waits) begin
          chk("bus_phase_expected", 32'(bus_q.size() != 0), 32'd1);
          if (bus_q.size() != 0) begin
            cur_b = bus_q.pop_front();
            chk("bus_adr", bus.ADR_O, cur_b.adr);
            chk("bus_sel", 32'(bus.SEL_O), 32'(cur_b.sel));
            chk("bus_we", 32'(bus.WE_O), 32'(cur_b.we));
            if (cur_b.we) chk("bus_dat", bus.DAT_O, cur_b.dat);
          end
          idx = bus.ADR_O[7:2];
          if (err_inject) begin
            bus.ERR_I = 1'b1;
            bus.ACK_I = 1'b1;
          end else begin
            if (bus.WE_O) begin
              for (int k = 0; k < 4; k++) begin
                if (bus.SEL_O[k]) mem[idx][8*k +: 8] = bus.DAT_O[8*k +: 8];
              end
            end
            bus.DAT_I = mem[idx];
            bus.ACK_I = 1'b1;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur_r = exp_q.pop_front();
        chk("resp_err", 32'(resp_err), 32'(cur_r.err));
        chk("resp_rdata", resp_rdata, cur_r.rdata);
      end
    end
  end

  task automatic expect_bus(input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic we);
    bus_q.push_back('{adr: adr, sel: sel, dat: dat, we: we});
  endtask

  task automatic expect_resp(input logic err, input logic [31:0] rdata);
    exp_q.push_back('{err: err, rdata: rdata});
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, 32'(n < 50), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(bus.CYC_O), 32'd0);
    chk("rst_stb", 32'(bus.STB_O), 32'd0);
    chk("rst_we", 32'(bus.WE_O), 32'd0);
    chk("rst_sel", 32'(bus.SEL_O), 32'd0);
    chk("rst_adr", bus.ADR_O, 32'h0);
    chk("rst_dat", bus.DAT_O, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Byte read at offset 3, zero-wait.
    mem[4] = 32'hAABBCCDD;
    expect_bus(32'h10, 4'b0001, 32'h0, 1'b0);
    expect_resp(1'b0, 32'h000000DD);
    issue(1'b0, 2'd1, 32'h13, 32'h0);
    chk("byte_cyc_e0", 32'(bus.CYC_O), 32'd1);
    chk("byte_sel_e0", 32'(bus.SEL_O), 32'b0001);
    chk("byte_adr_e0", bus.ADR_O, 32'h10);
    chk("byte_ready_e0", 32'(req_ready), 32'd0);
    step();
    chk("byte_valid_e1", 32'(resp_valid), 32'd1);
    chk("byte_cyc_e1", 32'(bus.CYC_O), 32'd0);
    step();
    chk("byte_ready_e2", 32'(req_ready), 32'd1);
    chk("byte_valid_e2", 32'(resp_valid), 32'd0);
    wait_done("byte_rd");

    // Word write then read at offset 2.
    expect_bus(32'h20, 4'b0011, 32'h0000BEEF, 1'b1);
    expect_resp(1'b0, 32'h0);
    issue(1'b1, 2'd2, 32'h22, 32'h0000BEEF);
    chk("wordwr_we", 32'(bus.WE_O), 32'd1);
    chk("wordwr_dat", bus.DAT_O, 32'h0000BEEF);
    wait_done("word_wr");
    expect_bus(32'h20, 4'b0011, 32'h0, 1'b0);
    expect_resp(1'b0, 32'h0000BEEF);
    issue(1'b0, 2'd2, 32'h22, 32'h0);
    wait_done("word_rd");

    // Straddling long write and read back.
    expect_bus(32'h1C, 4'b0011, 32'h00001122, 1'b1);
    expect_bus(32'h20, 4'b1100, 32'h33440000, 1'b1);
    expect_resp(1'b0, 32'h0);
    issue(1'b1, 2'd3, 32'h1E, 32'h11223344);
    chk("split_cyc_e0", 32'(bus.CYC_O), 32'd1);
    step();
    chk("split_cyc_e1", 32'(bus.CYC_O), 32'd1);
    chk("split_adr_e1", bus.ADR_O, 32'h20);
    chk("split_valid_e1", 32'(resp_valid), 32'd0);
    step();
    chk("split_cyc_e2", 32'(bus.CYC_O), 32'd0);
    chk("split_valid_e2", 32'(resp_valid), 32'd1);
    wait_done("split_wr");
    expect_bus(32'h1C, 4'b0011, 32'h0, 1'b0);
    expect_bus(32'h20, 4'b1100, 32'h0, 1'b0);
    expect_resp(1'b0, 32'h11223344);
    issue(1'b0, 2'd3, 32'h1E, 32'h0);
    wait_done("split_rd");

    // Aligned long, byte merge into lane 2, reads of mixed sizes.
    expect_bus(32'h40, 4'b1111, 32'hCAFEF00D, 1'b1);
    expect_resp(1'b0, 32'h0);
    issue(1'b1, 2'd3, 32'h40, 32'hCAFEF00D);
    wait_done("long_wr");
    expect_bus(32'h40, 4'b0100, 32'h005A0000, 1'b1);
    expect_resp(1'b0, 32'h0);
    issue(1'b1, 2'd1, 32'h41, 32'h0000005A);
    wait_done("byte_wr");
    expect_bus(32'h40, 4'b1111, 32'h0, 1'b0);
    expect_resp(1'b0, 32'hCA5AF00D);
    issue(1'b0, 2'd3, 32'h40, 32'h0);
    wait_done("long_rd");
    expect_bus(32'h40, 4'b0010, 32'h0, 1'b0);
    expect_resp(1'b0, 32'h000000F0);
    issue(1'b0, 2'd1, 32'h42, 32'h0);
    wait_done("byte_rd2");
    expect_bus(32'h40, 4'b1100, 32'h0, 1'b0);
    expect_resp(1'b0, 32'h0000CA5A);
    issue(1'b0, 2'd2, 32'h40, 32'h0);
    wait_done("word_rd0");

    // Immediate faults: no bus cycle.
    expect_resp(1'b1, 32'h0);
    issue(1'b0, 2'd2, 32'h15, 32'h0);
    chk("odd_cyc", 32'(bus.CYC_O), 32'd0);
    chk("odd_valid", 32'(resp_valid), 32'd1);
    chk("odd_err", 32'(resp_err), 32'd1);
    step();
    chk("odd_ready", 32'(req_ready), 32'd1);
    wait_done("odd_word");
    expect_resp(1'b1, 32'h0);
    issue(1'b0, 2'd0, 32'h40, 32'h0);
    chk("size0_cyc", 32'(bus.CYC_O), 32'd0);
    wait_done("size0");
    expect_resp(1'b1, 32'h0);
    issue(1'b1, 2'd3, 32'h43, 32'hFFFFFFFF);
    chk("oddlong_cyc", 32'(bus.CYC_O), 32'd0);
    wait_done("odd_long");

    // ERR together with ACK in phase 1 of a split long: no phase 2.
    err_inject = 1'b1;
    expect_bus(32'h1C, 4'b0011, 32'h0, 1'b0);
    expect_resp(1'b1, 32'h0);
    issue(1'b0, 2'd3, 32'h1E, 32'h0);
    wait_done("split_err");
    err_inject = 1'b0;

    // Two wait states: bus held stable until termination.
    waits = 2;
    expect_bus(32'h20, 4'b1100, 32'h12340000, 1'b1);
    expect_resp(1'b0, 32'h0);
    issue(1'b1, 2'd2, 32'h20, 32'h00001234);
    step();
    chk("ws_cyc_e1", 32'(bus.CYC_O), 32'd1);
    chk("ws_dat_e1", bus.DAT_O, 32'h12340000);
    step();
    chk("ws_adr_e2", bus.ADR_O, 32'h20);
    chk("ws_valid_e2", 32'(resp_valid), 32'd0);
    step();
    chk("ws_cyc_e3", 32'(bus.CYC_O), 32'd0);
    chk("ws_valid_e3", 32'(resp_valid), 32'd1);
    wait_done("wait_wr");
    waits = 0;

    // Silent responder, TIMEOUT of 4.
    silent = 1'b1;
    expect_resp(1'b1, 32'h0);
    issue(1'b0, 2'd3, 32'h40, 32'h0);
    repeat (3) step();
    chk("tmo_cyc_e3", 32'(bus.CYC_O), 32'd1);
    chk("tmo_valid_e3", 32'(resp_valid), 32'd0);
    step();
    chk("tmo_cyc_e4", 32'(bus.CYC_O), 32'd0);
    chk("tmo_valid_e4", 32'(resp_valid), 32'd1);
    chk("tmo_err_e4", 32'(resp_err), 32'd1);
    wait_done("timeout");
    silent = 1'b0;

    // Long straddling the top of the address space wraps to 0.
    expect_bus(32'hFFFFFFFC, 4'b0011, 32'h0000A1B2, 1'b1);
    expect_bus(32'h00000000, 4'b1100, 32'hC3D40000, 1'b1);
    expect_resp(1'b0, 32'h0);
    issue(1'b1, 2'd3, 32'hFFFFFFFE, 32'hA1B2C3D4);
    wait_done("wrap_wr");
    expect_bus(32'hFFFFFFFC, 4'b0011, 32'h0, 1'b0);
    expect_bus(32'h00000000, 4'b1100, 32'h0, 1'b0);
    expect_resp(1'b0, 32'hA1B2C3D4);
    issue(1'b0, 2'd3, 32'hFFFFFFFE, 32'h0);
    wait_done("wrap_rd");

    // Reset during a waited phase: bus drops, no response.
    waits = 3;
    issue(1'b0, 2'd3, 32'h40, 32'h0);
    chk("rstmid_cyc_e0", 32'(bus.CYC_O), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    chk("rstmid_cyc", 32'(bus.CYC_O), 32'd0);
    chk("rstmid_stb", 32'(bus.STB_O), 32'd0);
    chk("rstmid_sel", 32'(bus.SEL_O), 32'd0);
    chk("rstmid_adr", bus.ADR_O, 32'h0);
    chk("rstmid_valid", 32'(resp_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    repeat (6) step();
    waits = 0;

    chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
